uart_tx_frame_ctrl: RTL

Frame sequencer that sits directly upstream of the UART transmitter 4:1 output multiplexer. It accepts a parallel byte with a valid strobe and serializes it LSB first. It generates the mux select sequence start, data, optional parity, then stop. It supplies the serial data bit and parity bit to the mux data inputs. The clock is the baud-rate clock: one frame bit per cycle.

---
 rtl/uart_tx_pkg.sv | 53 +++++
 rtl/uart_tx_serializer.sv | 59 +++++
 rtl/uart_tx_frame_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit frame sequencer: mux select codes,
// FSM state encoding, parity type constants and small helper functions.
package uart_tx_pkg;

    localparam logic [1:0] SEL_START = 2'b00;
    localparam logic [1:0] SEL_STOP  = 2'b01;
    localparam logic [1:0] SEL_DATA  = 2'b10;
    localparam logic [1:0] SEL_PAR   = 2'b11;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    // Mux select that must be on the line while the FSM sits in a given state.
    function automatic logic [1:0] sel_for_state(state_e st);
        logic [1:0] sel;
        sel = SEL_STOP;
        unique case (st)
            StStart:  sel = SEL_START;
            StData:   sel = SEL_DATA;
            StParity: sel = SEL_PAR;
            StIdle,
            StStop:   sel = SEL_STOP;
            default:  sel = SEL_STOP;
        endcase
        return sel;
    endfunction

    // Turns the XOR of a word into the transmitted parity bit.
    function automatic logic par_adjust(logic xor_v, logic par_typ);
        logic p;
        p = xor_v;
        case (par_typ)
            PAR_EVEN: p = xor_v;
            PAR_ODD:  p = ~xor_v;
            default:  p = xor_v;
        endcase
        return p;
    endfunction

    // Bit counter width; never below one bit so a 1-bit word still elaborates.
    function automatic int unsigned cnt_width(int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Shift register and bit counter for the data phase of a UART frame.
// Loaded on accept; each shift presents the next LSB on a registered output.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic                  shift_i,
    input  logic                  adv_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ser_data_o,
    output logic                  ser_done_o
);

    localparam int unsigned CntW = cnt_width(DATA_WIDTH);
    localparam logic [CntW-1:0] LastIdx = CntW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shreg_d, shreg_q;
    logic [CntW-1:0]       cnt_d, cnt_q;
    logic                  ser_d, ser_q;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        ser_d   = ser_q;
        if (load_i) begin
            shreg_d = data_i;
            cnt_d   = '0;
        end else begin
            if (shift_i) begin
                ser_d   = shreg_q[0];
                shreg_d = shreg_q >> 1;
            end
            // Saturates at the last index; the FSM leaves DATA on that cycle.
            if (adv_i && (cnt_q != LastIdx)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            ser_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            ser_q   <= ser_d;
        end
    end

    assign ser_data_o = ser_q;
    assign ser_done_o = (cnt_q == LastIdx);

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame sequencer: drives the 4:1 output mux select through
// start, data (LSB first), optional parity and stop, one bit per baud clock.
module uart_tx_frame_ctrl
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [1:0]            MUX_SEL,
    output logic                  SER_DATA,
    output logic                  PAR_BIT,
    output logic                  BUSY
);

    state_e     state_d, state_q;
    logic       par_en_d, par_en_q;
    logic       par_bit_d, par_bit_q;
    logic [1:0] mux_sel_d, mux_sel_q;
    logic       busy_d, busy_q;

    logic accept;
    logic ser_shift;
    logic ser_adv;
    logic ser_done;

    always_comb begin
        accept = DATA_VALID && ((state_q == StIdle) || (state_q == StStop));

        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StStart;
            end
            StStart: state_d = StData;
            StData: begin
                if (ser_done) state_d = par_en_q ? StParity : StStop;
            end
            StParity: state_d = StStop;
            StStop: state_d = accept ? StStart : StIdle;
            default: state_d = StIdle;
        endcase

        // Frame options and parity are captured once so mid-frame input changes are inert.
        par_en_d  = accept ? PAR_EN : par_en_q;
        par_bit_d = accept ? par_adjust(^P_DATA, PAR_TYP) : par_bit_q;

        // Outputs are registered from the next state so they change on the accepting edge.
        mux_sel_d = sel_for_state(state_d);
        busy_d    = (state_d != StIdle);

        ser_shift = (state_d == StData);
        ser_adv   = (state_q == StData) && (state_d == StData);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StIdle;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            mux_sel_q <= SEL_STOP;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            mux_sel_q <= mux_sel_d;
            busy_q    <= busy_d;
        end
    end

    uart_tx_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_serializer (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (accept),
        .shift_i    (ser_shift),
        .adv_i      (ser_adv),
        .data_i     (P_DATA),
        .ser_data_o (SER_DATA),
        .ser_done_o (ser_done)
    );

    assign MUX_SEL = mux_sel_q;
    assign PAR_BIT = par_bit_q;
    assign BUSY    = busy_q;

endmodule
